// File: rtl/trial_sequencer_pkg.sv
// rtl/trial_sequencer_pkg.sv - shared states, opcodes and status packing for trial_sequencer
package trial_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_ACQ   = 3'd2,
        ST_SEND  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    localparam logic [1:0] OP_PATTERN = 2'b00;
    localparam logic [1:0] OP_LENGTH  = 2'b01;
    localparam logic [1:0] OP_START   = 2'b10;
    localparam logic [1:0] OP_ABORT   = 2'b11;

    // Shared settle / timeout counter width; must hold timeout_cycles.
    localparam int CNT_W = 25;

    function automatic logic [7:0] pack_status(input logic fault, input logic busy,
                                               input state_e st);
        return {fault, busy, st, 3'b000};
    endfunction

endpackage

// File: rtl/trial_sequencer_if.sv
// rtl/trial_sequencer_if.sv - host command, controller handshake and status bundle
// slave:  used by trial_sequencer (takes commands/done strobes, drives reservoir/pulses/status)
// master: used by the host/controller side
interface trial_sequencer_if #(
    parameter int LOG_MAX_TRIALS = 6
);
    logic                      received;
    logic [7:0]                receive_byte;
    logic                      acq_done;
    logic                      send_done;
    logic                      res_input;
    logic                      res_enable;
    logic                      acquire_signal;
    logic                      send_signal;
    logic                      busy;
    logic                      fault;
    logic [LOG_MAX_TRIALS-1:0] trial_idx;
    logic [7:0]                status;

    modport slave (
        input  received, receive_byte, acq_done, send_done,
        output res_input, res_enable, acquire_signal, send_signal,
               busy, fault, trial_idx, status
    );

    modport master (
        output received, receive_byte, acq_done, send_done,
        input  res_input, res_enable, acquire_signal, send_signal,
               busy, fault, trial_idx, status
    );
endinterface

// File: rtl/trial_sequencer_cmd_decoder.sv
// rtl/trial_sequencer_cmd_decoder.sv - registers host bytes into one-cycle command strobes
// Ports: clk, rst_n (async active-low); received/receive_byte in;
//        pattern_wr, length_wr, start, abort strobes and 6-bit payload out.
module trial_sequencer_cmd_decoder
    import trial_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       received,
    input  logic [7:0] receive_byte,
    output logic       pattern_wr,
    output logic       length_wr,
    output logic       start,
    output logic       abort,
    output logic [5:0] payload
);

    logic       pattern_wr_q, pattern_wr_d;
    logic       length_wr_q,  length_wr_d;
    logic       start_q,      start_d;
    logic       abort_q,      abort_d;
    logic [5:0] payload_q,    payload_d;

    always_comb begin
        pattern_wr_d = 1'b0;
        length_wr_d  = 1'b0;
        start_d      = 1'b0;
        abort_d      = 1'b0;
        payload_d    = receive_byte[5:0];
        if (received) begin
            case (receive_byte[7:6])
                OP_PATTERN: pattern_wr_d = 1'b1;
                OP_LENGTH:  length_wr_d  = 1'b1;
                OP_START:   start_d      = 1'b1;
                default:    abort_d      = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_wr_q <= 1'b0;
            length_wr_q  <= 1'b0;
            start_q      <= 1'b0;
            abort_q      <= 1'b0;
            payload_q    <= '0;
        end else begin
            pattern_wr_q <= pattern_wr_d;
            length_wr_q  <= length_wr_d;
            start_q      <= start_d;
            abort_q      <= abort_d;
            payload_q    <= payload_d;
        end
    end

    assign pattern_wr = pattern_wr_q;
    assign length_wr  = length_wr_q;
    assign start      = start_q;
    assign abort      = abort_q;
    assign payload    = payload_q;

endmodule

// File: rtl/trial_sequencer.sv
// rtl/trial_sequencer.sv - batch scheduler: drive bit, settle, acquire, send, per trial
// Ports: CLOCK_50 clock; reset async active-low; bus (slave modport) carries host
//        commands, acq_done/send_done strobes, reservoir drive, pulses and status.
// The acquisition length (nr_samples) is owned by the acquire controller.
module trial_sequencer
    import trial_sequencer_pkg::*;
#(
    parameter int MAX_TRIALS     = 64,
    parameter int LOG_MAX_TRIALS = 6,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    trial_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic       pattern_wr, length_wr, start, abort;
    logic [5:0] payload;

    trial_sequencer_cmd_decoder u_cmd_decoder (
        .clk          (CLOCK_50),
        .rst_n        (reset),
        .received     (bus.received),
        .receive_byte (bus.receive_byte),
        .pattern_wr   (pattern_wr),
        .length_wr    (length_wr),
        .start        (start),
        .abort        (abort),
        .payload      (payload)
    );

    state_e                    state_q, state_d;
    logic [MAX_TRIALS-1:0]     pattern_q, pattern_d;
    logic [LOG_MAX_TRIALS-1:0] len_q, len_d;
    logic [LOG_MAX_TRIALS-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      acq_pulse_q, acq_pulse_d;
    logic                      send_pulse_q, send_pulse_d;
    logic                      idle_like;
    logic [LOG_MAX_TRIALS-1:0] last_idx;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_FAULT);
    // A length of 0 wraps to all-ones, i.e. max_trials-1.
    assign last_idx  = len_q - LOG_MAX_TRIALS'(1);

    always_comb begin
        state_d      = state_q;
        pattern_d    = pattern_q;
        len_d        = len_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        acq_pulse_d  = 1'b0;
        send_pulse_d = 1'b0;

        if (idle_like) begin
            if (pattern_wr) pattern_d = (pattern_q << 6) | MAX_TRIALS'(payload);
            if (length_wr)  len_d     = payload[LOG_MAX_TRIALS-1:0];
        end

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAULT: begin
                    if (start) begin
                        state_d = ST_DRIVE;
                        idx_d   = '0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d     = ST_ACQ;
                        acq_pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ACQ: begin
                    // acq_done coincident with our own trigger pulse is ignored;
                    // a done strobe in the timeout cycle still wins.
                    if (bus.acq_done && !acq_pulse_q) begin
                        state_d      = ST_SEND;
                        send_pulse_d = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (bus.send_done) begin
                        state_d = ST_NEXT;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (idx_q == last_idx) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRIVE;
                        idx_d   = idx_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Settle and timeout share one counter, restarted on every state entry.
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pattern_q    <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            acq_pulse_q  <= 1'b0;
            send_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            acq_pulse_q  <= acq_pulse_d;
            send_pulse_q <= send_pulse_d;
        end
    end

    assign bus.res_enable     = (state_q == ST_DRIVE) || (state_q == ST_ACQ);
    assign bus.res_input      = bus.res_enable & pattern_q[idx_q];
    assign bus.acquire_signal = acq_pulse_q;
    assign bus.send_signal    = send_pulse_q;
    assign bus.fault          = (state_q == ST_FAULT);
    assign bus.busy           = !idle_like;
    assign bus.trial_idx      = idx_q;
    assign bus.status         = pack_status(bus.fault, bus.busy, state_q);

endmodule
